// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter multiplexing NREQ requesters onto one single-word memory controller.
// All outputs registered; a watchdog aborts transactions the controller never finishes.
module mem_port_arbiter #(
    parameter int NREQ    = 2,
    parameter int ADDR_W  = 30,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1023,
    localparam int OW     = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int TW     = $clog2(TIMEOUT + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          req_rw,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_wdata,
    output logic [NREQ-1:0]          ack,
    output logic                     ack_err,
    output logic [DATA_W-1:0]        rd_data,
    output logic [OW-1:0]            owner,
    output logic                     busy,
    output logic                     timeout_flag,
    input  logic                     mem_ready,
    output logic                     mem_op,
    output logic                     mem_rw,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata,
    input  logic                     mem_data_ready
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_RD, WAIT_WR, DONE} state_t;

    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
    localparam logic [OW:0]   NREQ_C  = (OW + 1)'(NREQ);

    state_t          state;
    logic [TW-1:0]   wd_cnt;
    logic            found;
    logic [OW-1:0]   win;
    logic [OW:0]     cand;

    // owner doubles as last_grant: search starts just above it and wraps.
    always_comb begin
        found = 1'b0;
        win   = owner;
        cand  = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = {1'b0, owner} + (OW + 1)'(i);
            if (cand >= NREQ_C)
                cand = cand - NREQ_C;
            if (!found && req[cand[OW-1:0]]) begin
                found = 1'b1;
                win   = cand[OW-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            ack          <= '0;
            ack_err      <= 1'b0;
            rd_data      <= '0;
            owner        <= OW'(NREQ - 1);
            busy         <= 1'b0;
            timeout_flag <= 1'b0;
            mem_op       <= 1'b0;
            mem_rw       <= 1'b1;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            wd_cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_ready && found) begin
                        owner     <= win;
                        mem_rw    <= req_rw[win];
                        mem_addr  <= req_addr[win*ADDR_W +: ADDR_W];
                        mem_wdata <= req_wdata[win*DATA_W +: DATA_W];
                        mem_op    <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_op <= 1'b0;
                    wd_cnt <= '0;
                    state  <= mem_rw ? WAIT_RD : WAIT_WR;
                end
                WAIT_RD: begin
                    if (mem_data_ready) begin
                        rd_data <= mem_rdata;
                        ack     <= NREQ'(1) << owner;
                        ack_err <= 1'b0;
                        state   <= DONE;
                    end else if (wd_cnt == TO_LAST) begin
                        ack          <= NREQ'(1) << owner;
                        ack_err      <= 1'b1;
                        timeout_flag <= 1'b1;
                        state        <= DONE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                WAIT_WR: begin
                    // Controller's ready is still high on the first cycle after mem_op.
                    if (wd_cnt != '0 && mem_ready) begin
                        ack     <= NREQ'(1) << owner;
                        ack_err <= 1'b0;
                        state   <= DONE;
                    end else if (wd_cnt == TO_LAST) begin
                        ack          <= NREQ'(1) << owner;
                        ack_err      <= 1'b1;
                        timeout_flag <= 1'b1;
                        state        <= DONE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                DONE: begin
                    ack     <= '0;
                    ack_err <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural controller model and an expected-ack queue.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req, req_rw;
    logic [59:0] req_addr;
    logic [63:0] req_wdata;
    logic [1:0]  ack;
    logic        ack_err;
    logic [31:0] rd_data;
    logic [0:0]  owner;
    logic        busy, timeout_flag;
    logic        mem_ready, mem_op, mem_rw;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_data_ready;

    mem_port_arbiter #(.NREQ(2), .ADDR_W(30), .DATA_W(32), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .req(req), .req_rw(req_rw), .req_addr(req_addr),
        .req_wdata(req_wdata), .ack(ack), .ack_err(ack_err), .rd_data(rd_data),
        .owner(owner), .busy(busy), .timeout_flag(timeout_flag), .mem_ready(mem_ready),
        .mem_op(mem_op), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_data_ready(mem_data_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          idx;
        bit          err;
        bit          rw;
        logic [29:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   op_cyc = 0;
    logic [31:0] rd_exp;

    // Controller model settings, written by the stimulus sequence
    int          md_wr_low = 3;
    int          md_rd_lat = 4;
    bit          md_rd_never = 1'b0;
    bit          md_release = 1'b0;
    logic [31:0] md_rd_val = 32'h0;
    bit          md_active = 1'b0;
    bit          md_rw = 1'b0;
    int          md_k = 0;

    initial begin
        mem_ready      = 1'b1;
        mem_data_ready = 1'b0;
        mem_rdata      = 32'h0;
        forever begin
            @(negedge clk);
            if (reset === 1'b1) begin
                md_active      = 1'b0;
                mem_ready      = 1'b1;
                mem_data_ready = 1'b0;
            end else if (md_active) begin
                md_k++;
                mem_data_ready = 1'b0;
                if (!md_rw) begin
                    mem_ready = (md_k > md_wr_low);
                    if (mem_ready) md_active = 1'b0;
                end else if (md_rd_never) begin
                    mem_ready = md_release;
                    if (md_release) md_active = 1'b0;
                end else if (md_k == md_rd_lat) begin
                    mem_ready      = 1'b0;
                    mem_data_ready = 1'b1;
                    mem_rdata      = md_rd_val;
                end else if (md_k > md_rd_lat) begin
                    mem_ready = 1'b1;
                    md_active = 1'b0;
                end else begin
                    mem_ready = 1'b0;
                end
            end else if (mem_op === 1'b1) begin
                md_active = 1'b1;
                md_k      = 0;
                md_rw     = mem_rw;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
        tests++;
        assert (obs === want) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, want);
        end
    endtask

    task automatic push(input int idx, input bit err, input bit rw, input logic [29:0] a,
                        input logic [31:0] d, input logic [31:0] rd, input int lat);
        exp_t e;
        e.idx = idx; e.err = err; e.rw = rw; e.addr = a; e.wdata = d; e.rdata = rd; e.lat = lat;
        sb.push_back(e);
    endtask

    task automatic wait_op(input string tag);
        exp_t e;
        int n;
        e = sb[0];
        n = 0;
        while (mem_op !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_op_seen"}, 64'(n < 200), 64'd1);
        op_cyc = cyc;
        check({tag, "_op_rw"}, 64'(mem_rw), 64'(e.rw));
        check({tag, "_op_addr"}, 64'(mem_addr), 64'(e.addr));
        if (!e.rw) check({tag, "_op_wdata"}, 64'(mem_wdata), 64'(e.wdata));
    endtask

    task automatic wait_ack(input string tag);
        exp_t e;
        int n, extra;
        e = sb.pop_front();
        n = 0;
        extra = 0;
        @(negedge clk);
        while (ack === 2'b00 && n < 200) begin
            if (mem_op === 1'b1) extra++;
            @(negedge clk);
            n++;
        end
        check({tag, "_ack_seen"}, 64'(n < 200), 64'd1);
        check({tag, "_ack_vec"}, 64'(ack), 64'(1) << e.idx);
        check({tag, "_owner"}, 64'(owner), 64'(e.idx));
        check({tag, "_ack_err"}, 64'(ack_err), 64'(e.err));
        check({tag, "_rd_data"}, 64'(rd_data), 64'(e.rdata));
        check({tag, "_latency"}, 64'(cyc - op_cyc), 64'(e.lat));
        check({tag, "_addr_held"}, 64'(mem_addr), 64'(e.addr));
        check({tag, "_single_op"}, 64'(extra), 64'd0);
        @(negedge clk);
        check({tag, "_ack_pulse"}, 64'(ack), 64'd0);
    endtask

    initial begin
        int n;
        reset     = 1'b1;
        req       = 2'b00;
        req_rw    = 2'b00;
        req_addr  = '0;
        req_wdata = '0;
        rd_exp    = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_ack", 64'(ack), 64'd0);
        check("rst_ack_err", 64'(ack_err), 64'd0);
        check("rst_mem_op", 64'(mem_op), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_tflag", 64'(timeout_flag), 64'd0);
        check("rst_rd_data", 64'(rd_data), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        check("rst_mem_rw", 64'(mem_rw), 64'd1);
        check("rst_owner", 64'(owner), 64'd1);
        reset = 1'b0;
        @(negedge clk);

        // Single write from requester 0; address changed right after grant
        md_wr_low = 3;
        req_rw[0] = 1'b0;
        req_addr[29:0] = 30'h100;
        req_wdata[31:0] = 32'hDEADBEEF;
        push(0, 1'b0, 1'b0, 30'h100, 32'hDEADBEEF, rd_exp, 5);
        req = 2'b01;
        wait_op("wr0");
        check("wr0_busy", 64'(busy), 64'd1);
        req_addr[29:0] = 30'h999;
        wait_ack("wr0");
        req = 2'b00;
        repeat (2) @(negedge clk);
        check("wr0_addr_kept", 64'(mem_addr), 64'h100);
        check("idle_busy", 64'(busy), 64'd0);

        // Single read from requester 1
        md_rd_lat = 4;
        md_rd_val = 32'h12345678;
        req_rw[1] = 1'b1;
        req_addr[59:30] = 30'h40;
        rd_exp = 32'h12345678;
        push(1, 1'b0, 1'b1, 30'h40, 32'h0, rd_exp, 5);
        req = 2'b10;
        wait_op("rd1");
        wait_ack("rd1");
        req = 2'b00;
        @(negedge clk);

        // Fairness: both requesters held for six transactions
        md_wr_low = 1;
        req_rw = 2'b00;
        req_addr = {30'h300, 30'h200};
        req_wdata = {32'hB1B11111, 32'hA0A00000};
        for (int t = 0; t < 6; t++)
            push(t % 2, 1'b0, 1'b0, (t % 2) ? 30'h300 : 30'h200,
                 (t % 2) ? 32'hB1B11111 : 32'hA0A00000, rd_exp, 3);
        req = 2'b11;
        for (int t = 0; t < 6; t++) begin
            wait_op("fair");
            wait_ack("fair");
        end
        req = 2'b00;
        repeat (2) @(negedge clk);

        // Read that the controller never completes
        md_rd_never = 1'b1;
        md_release = 1'b0;
        req_rw[0] = 1'b1;
        req_addr[29:0] = 30'h80;
        push(0, 1'b1, 1'b1, 30'h80, 32'h0, rd_exp, 9);
        req = 2'b01;
        wait_op("tmo");
        wait_ack("tmo");
        check("tmo_flag", 64'(timeout_flag), 64'd1);
        req = 2'b10;
        n = 0;
        repeat (6) begin
            @(negedge clk);
            if (mem_op === 1'b1) n++;
        end
        check("tmo_no_grant_while_not_ready", 64'(n), 64'd0);
        push(1, 1'b0, 1'b0, 30'h300, 32'hB1B11111, rd_exp, 3);
        md_release = 1'b1;
        wait_op("post_tmo");
        md_rd_never = 1'b0;
        md_release = 1'b0;
        wait_ack("post_tmo");
        req = 2'b00;
        check("tmo_flag_sticky", 64'(timeout_flag), 64'd1);
        repeat (2) @(negedge clk);

        // Reset during a read
        md_rd_lat = 20;
        req_rw[0] = 1'b1;
        req_addr[29:0] = 30'h40;
        push(0, 1'b0, 1'b1, 30'h40, 32'h0, rd_exp, 21);
        req = 2'b01;
        wait_op("rst_mid");
        void'(sb.pop_front());
        repeat (3) @(negedge clk);
        reset = 1'b1;
        req = 2'b00;
        #1;
        check("rstmid_busy", 64'(busy), 64'd0);
        check("rstmid_mem_op", 64'(mem_op), 64'd0);
        check("rstmid_tflag", 64'(timeout_flag), 64'd0);
        n = 0;
        repeat (4) begin
            @(negedge clk);
            if (ack !== 2'b00) n++;
        end
        check("rstmid_no_ack", 64'(n), 64'd0);
        reset = 1'b0;
        rd_exp = 32'h0;
        md_wr_low = 1;
        req_rw = 2'b00;
        push(0, 1'b0, 1'b0, 30'h200, 32'hA0A00000, rd_exp, 3);
        push(1, 1'b0, 1'b0, 30'h300, 32'hB1B11111, rd_exp, 3);
        req_addr = {30'h300, 30'h200};
        @(negedge clk);
        req = 2'b11;
        wait_op("after_rst0");
        wait_ack("after_rst0");
        wait_op("after_rst1");
        wait_ack("after_rst1");
        req = 2'b00;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench did not finish");
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Round-robin arbiter sharing one single-word DDR2 memory read/write controller between NREQ requesters, e.g. the event writer and the USB readout reader.
- Sits between the requesters and the controller's ready / mem_op / read_write / addr / data_in / data_out / data_ready interface.
- Serialises transactions and returns read data with a one-cycle acknowledge.
- A watchdog aborts transactions the controller never completes.

Parameters:
- NREQ, 2, number of requesters (2..8).
- ADDR_W, 30, byte address width.
- DATA_W, 32, data width.
- TIMEOUT, 1023, cycles allowed in a wait state before abort (TW = clog2(TIMEOUT+1) bits).

Ports:
- clk  in  1  clock.
- reset  in  1  reset.
- req  in  NREQ  per-requester request level.
- req_rw  in  NREQ  per-requester op: 1 = read, 0 = write.
- req_addr  in  NREQ*ADDR_W  packed addresses; requester i uses bits [i*ADDR_W +: ADDR_W].
- req_wdata  in  NREQ*DATA_W  packed write data, same packing.
- ack  out  NREQ  one-cycle completion strobe per requester.
- ack_err  out  1  qualifies ack: 1 = transaction aborted by timeout.
- rd_data  out  DATA_W  read data, valid while ack is high for a read.
- owner  out  clog2(NREQ)  index of the current or last granted requester.
- busy  out  1  high in every state except IDLE.
- timeout_flag  out  1  sticky; set by any timeout, cleared only by reset.
- mem_ready  in  1  controller idle/ready.
- mem_op  out  1  controller start strobe.
- mem_rw  out  1  to controller read_write.
- mem_addr  out  ADDR_W  to controller addr.
- mem_wdata  out  DATA_W  to controller data_in.
- mem_rdata  in  DATA_W  from controller data_out.
- mem_data_ready  in  1  controller read-data strobe.

Behaviour:
- Reset (reset, asynchronous, active-high; clock clk): state IDLE.
  - Outputs: ack = 0, ack_err = 0, mem_op = 0, busy = 0, timeout_flag = 0, rd_data = 0, mem_addr = 0, mem_wdata = 0, mem_rw = 1.
  - Internal: last_grant = NREQ-1, so requester 0 has first priority. owner = NREQ-1.
- All outputs are registered.
- States: IDLE, ISSUE, WAIT_RD, WAIT_WR, DONE.
- IDLE:
  - Arbitrates only when mem_ready = 1 and req != 0.
  - Search order: (last_grant+1) mod NREQ upward, wrapping.
  - Winner: latch index into owner/last_grant; latch req_rw, address and wdata into mem_rw/mem_addr/mem_wdata. Next state ISSUE.
  - Requests arriving while mem_ready = 0 wait; no starvation.
- ISSUE: mem_op = 1 for exactly this cycle.
  - Next state WAIT_RD if mem_rw = 1, else WAIT_WR.
  - Watchdog counter cleared.
- WAIT_WR:
  - The first cycle is ignored; the controller's ready drops one cycle after mem_op.
  - From the second cycle, mem_ready = 1 means done: ack[owner] = 1, ack_err = 0, go to DONE.
- WAIT_RD: on mem_data_ready = 1, rd_data <= mem_rdata, ack[owner] = 1, ack_err = 0, go to DONE.
  - mem_data_ready seen in any other state is ignored.
- Watchdog: counter increments each cycle in WAIT_RD/WAIT_WR.
  - On reaching TIMEOUT: ack[owner] = 1, ack_err = 1, timeout_flag = 1, rd_data unchanged, go to DONE.
  - The next grant still waits for mem_ready = 1 in IDLE.
- DONE: ack and ack_err return to 0. No arbitration this cycle. Next state IDLE.
- Handshake:
  - The requester holds req, req_rw, addr and wdata stable from assertion until it sees ack.
  - It drops req on the cycle after ack unless it has a new request.
  - Inputs are sampled only at grant; changes afterwards do not affect the transaction in flight.
  - Dropping req before ack does not cancel the transaction; ack is still issued.
- Latency: grant to mem_op is 1 cycle. A write acks 1 cycle after mem_ready rises; a read acks 1 cycle after mem_data_ready.
- Back-to-back:
  - A requester re-requesting immediately after its ack yields to any other pending requester.
  - A sole requester may be re-granted; minimum 5 cycles between its acks.
- Reset mid-transaction: immediate return to IDLE with reset output values. No ack is issued for the aborted transaction.

Test Plan:
- Single write, NREQ = 2: req[0] = 1, rw = 0, addr = 0x0000_0100, wdata = 0xDEADBEEF. Controller model ready low for 3 cycles → mem_op for one cycle carrying those values; ack[0] one cycle after ready returns; ack_err = 0.
- Single read: req[1], addr = 0x40, model returns 0x12345678 with data_ready 4 cycles after mem_op → rd_data = 0x12345678 on the ack[1] cycle; owner = 1.
- Fairness: req = 2'b11 held continuously for 6 transactions → grant order 0,1,0,1,0,1; no back-to-back repeat while the other is pending.
- Timeout: TIMEOUT = 8, model never asserts data_ready → ack[owner] with ack_err = 1 exactly 8 cycles after entering WAIT_RD; timeout_flag stays 1; the next grant occurs only after mem_ready = 1.
- Stability: change req_addr[0] to 0x999 one cycle after grant → mem_addr keeps the latched 0x100 until the next grant.
- Reset mid-read: assert reset during WAIT_RD → busy = 0, no ack, mem_op = 0; after release, requester 0 wins first.
